vedic_mul_sched: RTL

Multi-requester scheduler that shares a single `vedic32x32` unsigned multiplier between `NREQ` clients. It performs round-robin arbitration and registers the granted operands. It times the multiplier's combinational path as a fixed `LAT`-cycle multicycle path, then returns the 64-bit product with the requester's ID over a valid/ready response channel. It sits between the client request ports and the multiplier datapath; the multiplier itself is instantiated unchanged inside this block.

---
 rtl/vedic_mul_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vedic_mul_sched.sv
// Round-robin scheduler sharing one vedic32x32 multiplier between NREQ requesters.
// The multiplier path from op_a/op_b to rsp_data is a LAT-cycle multicycle path.

module vedic_nxn #(
    parameter int W = 32
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    generate
        if (W == 2) begin : g_base
            logic t0, t1, t2, t3, c;
            assign t0   = a[0] & b[0];
            assign t1   = a[1] & b[0];
            assign t2   = a[0] & b[1];
            assign t3   = a[1] & b[1];
            assign c    = t1 & t2;
            assign p[0] = t0;
            assign p[1] = t1 ^ t2;
            assign p[2] = t3 ^ c;
            assign p[3] = t3 & c;
        end else begin : g_rec
            localparam int H = W / 2;
            logic [W-1:0] ll, lh, hl, hh;
            logic [W:0]   mid;
            vedic_nxn #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
            vedic_nxn #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
            vedic_nxn #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
            vedic_nxn #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
            // Urdhva combine: outer products concatenate, cross terms add at offset H
            assign mid = {1'b0, lh} + {1'b0, hl};
            assign p   = {hh, ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
        end
    endgenerate
endmodule

module vedic32x32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    vedic_nxn #(.W(32)) u_core (.a(a), .b(b), .p(p));
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// req_valid/req_a/req_b and rsp_valid/rsp_data/rsp_id are held stable until then.
module vedic_mul_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          op_count,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTRW:0] NREQ_W = (PTRW+1)'(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [PTRW-1:0] ptr, id, gnt;
    logic            gnt_ok;
    logic [NREQ-1:0] rot;
    logic [PTRW:0]   sum;
    logic [3:0]      cnt;
    logic [31:0]     op_a, op_b;
    logic [63:0]     mul_p;

    vedic32x32 u_mul (.a(op_a), .b(op_b), .p(mul_p));

    assign dbg_state = state;

    // Rotate so ptr sits at bit 0; the lowest set bit is the offset of the grant.
    always_comb begin
        rot    = NREQ'({req_valid, req_valid} >> ptr);
        gnt_ok = 1'b0;
        gnt    = '0;
        sum    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr} + (PTRW+1)'(i);
                if (sum >= NREQ_W) sum = sum - NREQ_W;
                gnt_ok = 1'b1;
                gnt    = sum[PTRW-1:0];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            S_IDLE: begin
                if (gnt_ok) begin
                    req_ready[gnt] = ~rst;
                    state_nx       = S_BUSY;
                end
            end
            S_BUSY: if (cnt == 4'd0) state_nx = S_RESP;
            S_RESP: if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            id        <= '0;
            cnt       <= 4'd0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 64'd0;
            rsp_id    <= '0;
            op_count  <= 32'd0;
            busy      <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (gnt_ok) begin
                        op_a <= req_a[32*gnt +: 32];
                        op_b <= req_b[32*gnt +: 32];
                        id   <= gnt;
                        cnt  <= 4'(LAT - 1);
                    end
                end
                S_BUSY: begin
                    // op_a/op_b have been stable for LAT cycles when cnt reaches 0
                    if (cnt == 4'd0) begin
                        rsp_data  <= mul_p;
                        rsp_id    <= IDW'(id);
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (id == PTRW'(NREQ - 1)) ? '0 : id + 1'b1;
                        op_count  <= op_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
